w0rm_alu_sequencer: RTL and testbench

Controller that sequences the W0RM core ALU functional units: logic, multiply, div/rem, add/sub and shifts. It accepts one operation at a time from the execute stage over a valid/ready handshake and decodes the opcode to a single unit. It issues a one-cycle start pulse with registered operands, waits for that unit's result with a timeout guard, and then returns the result. It also maintains the architectural Z/N/V/C flag register under a per-operation store mask.

---
 rtl/w0rm_alu_pkg.sv | 43 ++++
 rtl/w0rm_alu_unit_decode.sv | 24 ++
 rtl/w0rm_alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_w0rm_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_alu_pkg.sv
// Shared definitions for the W0RM ALU sequencer: opcodes, unit indices,
// flag bit positions and sequencer state encoding.
package w0rm_alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h3;
  localparam logic [3:0] OP_NEG = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_REM = 4'h7;
  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hC;
  localparam logic [3:0] OP_LSL = 4'hD;
  localparam logic [3:0] OP_ASR = 4'hE;

  localparam int UNIT_LOGIC  = 0;
  localparam int UNIT_MUL    = 1;
  localparam int UNIT_DIVREM = 2;
  localparam int UNIT_ADDSUB = 3;
  localparam int UNIT_SHIFTS = 4;
  localparam int NUM_UNITS   = 5;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;
  localparam int NUM_FLAGS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input int idx);
    return NUM_UNITS'(1) << idx;
  endfunction

endpackage

// File: rtl/w0rm_alu_unit_decode.sv
// Combinational opcode decode to a one-hot functional-unit select plus an
// illegal-opcode flag; shared by the sequencer and hazard logic.
module w0rm_alu_unit_decode
  import w0rm_alu_pkg::*;
(
  input  logic [3:0]           i_opcode,
  output logic [NUM_UNITS-1:0] o_sel,
  output logic                 o_illegal
);

  always_comb begin
    o_sel     = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG: o_sel = unit_onehot(UNIT_LOGIC);
      OP_MUL:                                o_sel = unit_onehot(UNIT_MUL);
      OP_DIV, OP_REM:                        o_sel = unit_onehot(UNIT_DIVREM);
      OP_ADD, OP_SUB:                        o_sel = unit_onehot(UNIT_ADDSUB);
      OP_LSR, OP_LSL, OP_ASR:                o_sel = unit_onehot(UNIT_SHIFTS);
      default:                               o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/w0rm_alu_sequencer.sv
// Sequences one ALU operation at a time onto a single functional unit,
// guards the wait with a timeout and maintains the masked Z/N/V/C flags.
module w0rm_alu_sequencer
  import w0rm_alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [3:0]                      in_opcode,
  input  logic [3:0]                      in_flags_mask,
  input  logic [DATA_WIDTH-1:0]           in_a,
  input  logic [DATA_WIDTH-1:0]           in_b,
  output logic [NUM_UNITS-1:0]            unit_start,
  output logic [3:0]                      unit_opcode,
  output logic [DATA_WIDTH-1:0]           unit_a,
  output logic [DATA_WIDTH-1:0]           unit_b,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  input  logic [NUM_UNITS*NUM_FLAGS-1:0]  unit_flags,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_result,
  output logic                            out_error,
  output logic [NUM_FLAGS-1:0]            flags
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [NUM_UNITS-1:0]    r_sel;
  logic [NUM_FLAGS-1:0]    r_mask;
  logic [NUM_FLAGS-1:0]    r_flags;
  logic [3:0]              r_opcode;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_error;
  logic [CNT_W-1:0]        r_cnt;

  logic [NUM_UNITS-1:0]    w_dec_sel;
  logic                    w_dec_illegal;
  logic                    w_accept;
  logic                    w_hit;
  logic                    w_timeout;
  logic [DATA_WIDTH-1:0]   w_sel_result;
  logic [NUM_FLAGS-1:0]    w_sel_flags;

  w0rm_alu_unit_decode u_decode (
    .i_opcode  (in_opcode),
    .o_sel     (w_dec_sel),
    .o_illegal (w_dec_illegal)
  );

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  // Only the latched unit can complete; strays from other units never match r_sel.
  assign w_hit     = (r_state == ST_WAIT) && |(unit_valid & r_sel);
  assign w_timeout = (r_state == ST_WAIT) && (r_cnt == CNT_LAST);

  always_comb begin
    w_sel_result = '0;
    w_sel_flags  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (r_sel[k]) begin
        w_sel_result = w_sel_result | unit_result[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_flags  = w_sel_flags  | unit_flags[k*NUM_FLAGS +: NUM_FLAGS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_next_state = w_dec_illegal ? ST_DONE : ST_ISSUE;
      ST_ISSUE: w_next_state = ST_WAIT;
      // A hit on the final counter cycle wins over the timeout.
      ST_WAIT:  if (w_hit || w_timeout) w_next_state = ST_DONE;
      ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == ST_IDLE);
    out_valid  = (r_state == ST_DONE);
    unit_start = (r_state == ST_ISSUE) ? r_sel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= '0;
      r_mask   <= '0;
      r_opcode <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_accept) begin
      r_sel    <= w_dec_sel;
      r_mask   <= in_flags_mask;
      r_opcode <= in_opcode;
      r_a      <= in_a;
      r_b      <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_error  <= 1'b0;
      r_flags  <= '0;
    end else if (w_accept && w_dec_illegal) begin
      r_result <= '0;
      r_error  <= 1'b1;
    end else if (w_hit) begin
      r_result <= w_sel_result;
      r_error  <= 1'b0;
      r_flags  <= (r_mask & w_sel_flags) | (~r_mask & r_flags);
    end else if (w_timeout) begin
      r_result <= '0;
      r_error  <= 1'b1;
    end
  end

  assign unit_opcode = r_opcode;
  assign unit_a      = r_a;
  assign unit_b      = r_b;
  assign out_result  = r_result;
  assign out_error   = r_error;
  assign flags       = r_flags;

endmodule

// File: tb/tb_w0rm_alu_sequencer.sv
// Scoreboard bench for w0rm_alu_sequencer: directed ops push expected
// completions, a monitor pops and compares on every output handshake.
module tb_w0rm_alu_sequencer;

  localparam int DW = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_opcode;
  logic [3:0]      in_flags_mask;
  logic [DW-1:0]   in_a, in_b;
  logic [4:0]      unit_start;
  logic [3:0]      unit_opcode;
  logic [DW-1:0]   unit_a, unit_b;
  logic [5*DW-1:0] unit_result;
  logic [4:0]      unit_valid;
  logic [19:0]     unit_flags;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_result;
  logic            out_error;
  logic [3:0]      flags;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
    logic [3:0] flg;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  w0rm_alu_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_flags_mask (in_flags_mask),
    .in_a          (in_a),
    .in_b          (in_b),
    .unit_start    (unit_start),
    .unit_opcode   (unit_opcode),
    .unit_a        (unit_a),
    .unit_b        (unit_b),
    .unit_result   (unit_result),
    .unit_valid    (unit_valid),
    .unit_flags    (unit_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_error     (out_error),
    .flags         (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int k, input logic [7:0] res, input logic [3:0] flg, input logic v);
    unit_result[k*DW +: DW] = res;
    unit_flags[k*4 +: 4]    = flg;
    unit_valid[k]           = v;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] mask);
    check("in_ready_before_issue", in_ready, 1);
    in_opcode     = op;
    in_a          = a;
    in_b          = b;
    in_flags_mask = mask;
    in_valid      = 1'b1;
    tick();
    in_valid      = 1'b0;
  endtask

  // Single-cycle unit latency: start in cycle 1, unit valid in cycle 2, out_valid in cycle 3.
  task automatic run_simple(input string name, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [3:0] mask, input int k,
                            input logic [4:0] exp_start, input logic [7:0] res,
                            input logic [3:0] uflg, input logic [3:0] exp_flags);
    exp_q.push_back('{res: res, err: 1'b0, flg: exp_flags});
    issue(op, a, b, mask);
    check({name, "_start_c1"}, unit_start, exp_start);
    check({name, "_unit_a"}, unit_a, a);
    check({name, "_unit_b"}, unit_b, b);
    check({name, "_unit_opcode"}, unit_opcode, op);
    tick();
    check({name, "_start_c2"}, unit_start, 0);
    check({name, "_valid_c2"}, out_valid, 0);
    set_unit(k, res, uflg, 1'b1);
    tick();
    set_unit(k, 8'h00, 4'h0, 1'b0);
    check({name, "_valid_c3"}, out_valid, 1);
    tick();
  endtask

  // Scoreboard monitor: compares on each output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", out_result);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", out_result, e.res);
          check("sb_error", out_error, e.err);
          check("sb_flags", flags, e.flg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_opcode     = 4'h0;
    in_flags_mask = 4'h0;
    in_a          = '0;
    in_b          = '0;
    unit_result   = '0;
    unit_valid    = '0;
    unit_flags    = '0;
    out_ready     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_unit_start", unit_start, 0);
    check("rst_flags", flags, 0);
    check("rst_unit_opcode", unit_opcode, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_error", out_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD 7F+01 -> 80, Z0 N1 V1 C0
    run_simple("add", 4'h8, 8'h7F, 8'h01, 4'hF, 3, 5'b01000, 8'h80, 4'b0110, 4'b0110);
    // preset all flags
    run_simple("sub", 4'h9, 8'h10, 8'h10, 4'hF, 3, 5'b01000, 8'h00, 4'b1111, 4'b1111);
    // only Z stored
    run_simple("and", 4'h0, 8'hF0, 8'h0F, 4'b0001, 0, 5'b00001, 8'h00, 4'b0000, 4'b1110);

    // illegal opcode A
    exp_q.push_back('{res: 8'h00, err: 1'b1, flg: 4'b1110});
    issue(4'hA, 8'h12, 8'h34, 4'hF);
    check("illegal_valid_c1", out_valid, 1);
    check("illegal_no_start", unit_start, 0);
    tick();
    check("illegal_back_idle", in_ready, 1);
    check("illegal_no_start_c2", unit_start, 0);

    // DIV timeout
    exp_q.push_back('{res: 8'h00, err: 1'b1, flg: 4'b1110});
    issue(4'h6, 8'h09, 8'h02, 4'hF);
    check("div_to_start_c1", unit_start, 5'b00100);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("div_to_valid_cycle", 1 + cyc, 2 + TO);
    tick();
    set_unit(2, 8'hAA, 4'b1111, 1'b1);
    tick();
    tick();
    check("late_valid_ignored", out_valid, 0);
    check("late_valid_flags", flags, 4'b1110);
    check("late_valid_in_ready", in_ready, 1);
    set_unit(2, 8'h00, 4'h0, 1'b0);

    // DIV valid on the counter limit cycle counts as success
    exp_q.push_back('{res: 8'h05, err: 1'b0, flg: 4'b1010});
    issue(4'h6, 8'h0F, 8'h03, 4'b0100);
    tick();
    repeat (TO - 1) tick();
    check("div_lim_valid_c9", out_valid, 0);
    set_unit(2, 8'h05, 4'b0000, 1'b1);
    tick();
    set_unit(2, 8'h00, 4'h0, 1'b0);
    check("div_lim_valid_c10", out_valid, 1);
    tick();

    // MUL with stray logic-unit valid and consumer backpressure
    exp_q.push_back('{res: 8'h06, err: 1'b0, flg: 4'b1010});
    out_ready = 1'b0;
    issue(4'h5, 8'h02, 8'h03, 4'b0000);
    check("mul_start_c1", unit_start, 5'b00010);
    tick();
    set_unit(0, 8'hFF, 4'b1111, 1'b1);
    tick();
    set_unit(0, 8'h00, 4'h0, 1'b0);
    check("mul_stray_ignored", out_valid, 0);
    set_unit(1, 8'h06, 4'b0000, 1'b1);
    tick();
    set_unit(1, 8'h00, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("mul_hold_valid", out_valid, 1);
      check("mul_hold_result", out_result, 8'h06);
      check("mul_hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("mul_back_idle", in_ready, 1);

    // reset during WAIT
    issue(4'h8, 8'h7F, 8'h01, 4'hF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_unit_a", unit_a, 0);
    check("mid_rst_unit_b", unit_b, 0);
    check("mid_rst_unit_opcode", unit_opcode, 0);
    check("mid_rst_flags", flags, 0);
    check("mid_rst_out_error", out_error, 0);
    set_unit(3, 8'h80, 4'b0110, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_unit(3, 8'h00, 4'h0, 1'b0);
    check("post_rst_no_valid", out_valid, 0);
    check("post_rst_flags", flags, 0);
    run_simple("add2", 4'h8, 8'h7F, 8'h01, 4'hF, 3, 5'b01000, 8'h80, 4'b0110, 4'b0110);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
